// File: rtl/apb_slave.sv
// apb_slave: APB byte-wide storage with a fixed number of wait states per access
// and an error response for addresses beyond DEPTH.
module apb_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [0:0] state;
    logic [3:0] cnt;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       write_q;
    logic [7:0] mem [DEPTH];
    logic       setup;
    logic       in_rng;
    logic       new_rng;

    assign setup   = state == IDLE && PSEL && !PENABLE;
    assign in_rng  = {24'd0, addr_q} < DEPTH;
    assign new_rng = {24'd0, PADDR} < DEPTH;
    assign PREADY  = state == ACCESS && cnt == 4'd0 && PSEL && PENABLE;
    assign PSLVERR = PREADY && !in_rng;

    // Read data is fetched at the setup edge so it is already stable once PREADY rises.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            write_q <= 1'b0;
            PRDATA  <= 8'h00;
        end else if (setup) begin
            state   <= ACCESS;
            cnt     <= 4'(WAIT_STATES);
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
            if (!PWRITE) PRDATA <= new_rng ? mem[PADDR[AW-1:0]] : 8'h00;
        end else if (state == ACCESS) begin
            if (!PSEL || PREADY) state <= IDLE;
            else if (PENABLE && cnt != 4'd0) cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (PREADY && write_q && in_rng) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: directed APB transfers against a 2-wait and a 0-wait instance,
// scoreboarded against a local memory model.
module tb_apb_slave;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       psel, penable, pwrite, use0;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata_a, prdata_b;
    logic       pready_a, pready_b, pslverr_a, pslverr_b;
    logic [7:0] prdata;
    logic       pready, pslverr;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         w;
        logic       rd;
    } exp_t;
    exp_t sb[$];

    logic [7:0] model_a [256];
    logic [7:0] model_b [256];
    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    apb_slave #(.DEPTH(64), .WAIT_STATES(2)) u_dut (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel && !use0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
    );

    apb_slave #(.DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel && use0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
    );

    assign prdata  = use0 ? prdata_b : prdata_a;
    assign pready  = use0 ? pready_b : pready_a;
    assign pslverr = use0 ? pslverr_b : pslverr_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            model_a[i] = 8'h00;
            model_b[i] = 8'h00;
        end
    endtask

    // Entered just after a rising edge; leaves just after the completion edge.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic scramble, input string tag);
        exp_t e;
        int   waits;
        e.rd = !wr;
        e.e  = a >= 8'd64;
        e.w  = use0 ? 0 : 2;
        e.d  = a < 8'd64 ? (use0 ? model_b[a] : model_a[a]) : 8'h00;
        if (wr && a < 8'd64) begin
            if (use0) model_b[a] = d;
            else model_a[a] = d;
        end
        sb.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk);
        #1 penable = 1'b1;
        if (scramble) begin
            paddr  = ~a;
            pwdata = ~d;
        end
        waits = 0;
        @(negedge clk);
        while (!pready && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({tag, "_waits"}, waits, e.w);
        chk({tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.e});
        if (e.rd) chk({tag, "_prdata"}, {24'd0, prdata}, {24'd0, e.d});
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; use0 = 1'b0;
        clear_models();
        #1;
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_prdata", {24'd0, prdata}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(1'b1, 8'h10, 8'hA5, 1'b0, "wr10");
        xfer(1'b0, 8'h10, 8'h00, 1'b0, "rd10");

        xfer(1'b1, 8'h40, 8'hFF, 1'b0, "wr40");
        xfer(1'b0, 8'h40, 8'h00, 1'b0, "rd40");
        xfer(1'b0, 8'h00, 8'h00, 1'b0, "rd00");
        xfer(1'b0, 8'h3F, 8'h00, 1'b0, "rd3f");

        xfer(1'b1, 8'h20, 8'h3C, 1'b0, "wr20");
        xfer(1'b0, 8'h20, 8'h00, 1'b0, "rd20");

        xfer(1'b1, 8'h30, 8'h99, 1'b1, "wr30s");
        xfer(1'b0, 8'h30, 8'h00, 1'b1, "rd30s");
        xfer(1'b0, 8'hCF, 8'h00, 1'b0, "rdcf");

        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h5A;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        chk("abort_wait", {31'd0, pready}, 32'd0);
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_pready", {31'd0, pready}, 32'd0);
        chk("abort_pslverr", {31'd0, pslverr}, 32'd0);
        @(posedge clk);
        #1;
        xfer(1'b0, 8'h05, 8'h00, 1'b0, "rd05");

        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_pready", {31'd0, pready}, 32'd0);
        end
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        xfer(1'b0, 8'h10, 8'h00, 1'b0, "rd10b");

        use0 = 1'b1;
        xfer(1'b1, 8'h01, 8'h11, 1'b0, "z_wr01");
        xfer(1'b1, 8'h02, 8'h22, 1'b0, "z_wr02");
        xfer(1'b0, 8'h01, 8'h00, 1'b0, "z_rd01");
        xfer(1'b0, 8'h02, 8'h00, 1'b0, "z_rd02");
        use0 = 1'b0;

        xfer(1'b1, 8'h03, 8'h77, 1'b0, "wr03");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h03;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pready", {31'd0, pready}, 32'd0);
        chk("arst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("arst_prdata", {24'd0, prdata}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        clear_models();
        @(posedge clk);
        #1 rst_n = 1'b1;
        xfer(1'b0, 8'h03, 8'h00, 1'b0, "rd03");
        xfer(1'b0, 8'h10, 8'h00, 1'b0, "rd10c");

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
